hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
Pipeline hazard sequencer for the 5-stage MIPS core; it sits beside the forwarding unit in the ID stage.
- Detects the hazards that forwarding cannot cover: load-use, jr-after-load and control redirects.
- Drives the PC/IF-ID write enables and the IF-ID / ID-EX flush (bubble) controls.
- A small FSM sequences multi-cycle stalls so that jr waiting on a load in EX holds for exactly two cycles.

Parameters:
- PCSRC_J, 3'b010, PCSrc encoding for j/jal decided in ID.
- PCSRC_JR, 3'b011, PCSrc encoding for jr/jalr decided in ID.
- CNT_W, 32, width of the perf counters (optional feature only).

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- PCSrc  in  3  next-PC select of the instruction in ID
- Rs, Rt  in  5 each  source registers of the instruction in ID
- UseRs, UseRt  in  1 each  ID instruction actually reads Rs/Rt
- MemRead_ex  in  1  load in EX
- RegWrite_ex  in  1  EX instruction writes a register
- Write_register  in  5  destination of the EX instruction
- MemRead_mem  in  1  load in MEM
- Write_register_mem  in  5  destination of the MEM instruction
- BranchTaken_ex  in  1  branch resolved taken in EX
- PCWrite  out  1  PC write enable
- IFIDWrite  out  1  IF/ID write enable
- IFIDFlush  out  1  IF/ID becomes a nop
- IDEXFlush  out  1  ID/EX becomes a bubble
- Stalling  out  1  high in any stall cycle
- StallCnt, FlushCnt  out  CNT_W each  perf counters (only with the optional feature)

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Output style: state is registered; outputs are combinational from state and inputs. Same-cycle decisions are required.
- Register $0 never creates a hazard.
- Reset (including mid-stall): state goes to RUN at that edge. While reset is high: PCWrite=1, IFIDWrite=1, all flushes=0, Stalling=0, counters=0.
- States: RUN, STALL1, JR_WAIT2, JR_WAIT1.
- Hazard terms:
  - lu = MemRead_ex & Write_register!=0 & ((UseRs & Rs==Write_register) | (UseRt & Rt==Write_register))
  - jrex = PCSrc==PCSRC_JR & MemRead_ex & Write_register!=0 & Rs==Write_register
  - jrmem = PCSrc==PCSRC_JR & MemRead_mem & Write_register_mem!=0 & Rs==Write_register_mem
  - jr after a non-load in EX is forwarded: no stall.
- Priority (highest first):
  1. BranchTaken_ex: IFIDFlush=1, IDEXFlush=1, PCWrite=1, IFIDWrite=1. Next state RUN; any stall in progress is aborted.
  2. jrex in RUN: stall this cycle (PCWrite=0, IFIDWrite=0, IDEXFlush=1), then JR_WAIT1. Total 2 stall cycles.
  3. lu or jrmem in RUN: one stall cycle with the same stall outputs; next state STALL1.
  4. PCSrc==PCSRC_J or PCSRC_JR with no hazard: IFIDFlush=1 (kill the fall-through fetch); no stall.
- JR_WAIT1: load now in MEM. Drive stall outputs, then go to STALL1.
- STALL1: re-evaluate the hazard terms exactly as in RUN (back-to-back hazards are legal). If none, release.
- JR_WAIT2: reserved encoding; behaves as JR_WAIT1.
- Stalling = PCWrite==0.
- Illegal state encodings return to RUN on the next edge.
- Flush and stall are never both asserted except IDEXFlush during a stall.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: StallCnt increments on every cycle with Stalling=1; FlushCnt increments on every cycle with IFIDFlush=1. Both saturate at all-ones and clear on reset.
- Not defined: the counter ports are absent and no counter flops exist.

Decomposition:
- Shared package hazard_pkg:
  - PCSrc encodings (PCSRC_J, PCSRC_JR)
  - FSM state encodings (2-bit)
  - CNT_W default
- One natural sub-module: hazard_perf_counter, a saturating counter with enable and synchronous clear, instantiated twice under HAZARD_PERF_CNT_EN.

Test Plan:
1. lw $5 in EX (MemRead_ex=1, Write_register=5), ID add uses Rs=5 -> one cycle PCWrite=0, IFIDWrite=0, IDEXFlush=1; next cycle all enables 1.
2. lw $8 in EX, ID jr $8 (PCSrc=3'b011) -> two consecutive stall cycles; third cycle IFIDFlush=1, PCWrite=1.
3. add $8 in EX (RegWrite_ex=1, MemRead_ex=0), ID jr $8 -> no stall; IFIDFlush=1 same cycle.
4. lw $0 in EX, ID uses Rs=0 -> no stall; Stalling=0.
5. Stall in JR_WAIT1 while BranchTaken_ex=1 -> both flushes=1, PCWrite=1; state RUN next cycle.
6. reset asserted during STALL1 -> next cycle PCWrite=1, Stalling=0. With HAZARD_PERF_CNT_EN: StallCnt=0 after reset and equals 3 after scenarios 1+2.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the ID-stage hazard/stall sequencer.
package hazard_pkg;

  localparam logic [2:0] PCSRC_J  = 3'b010;
  localparam logic [2:0] PCSRC_JR = 3'b011;
  localparam int unsigned CNT_W   = 32;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    STALL1   = 2'b01,
    JR_WAIT2 = 2'b10,
    JR_WAIT1 = 2'b11
  } hz_state_t;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter with enable and synchronous clear.
module hazard_perf_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (en && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use / jr-after-load stall and control-redirect flush sequencer.
// Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W_P = CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       PCSrc,
  input  logic [4:0]       Rs,
  input  logic [4:0]       Rt,
  input  logic             UseRs,
  input  logic             UseRt,
  input  logic             MemRead_ex,
  input  logic             RegWrite_ex,
  input  logic [4:0]       Write_register,
  input  logic             MemRead_mem,
  input  logic [4:0]       Write_register_mem,
  input  logic             BranchTaken_ex,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W_P-1:0] StallCnt,
  output logic [CNT_W_P-1:0] FlushCnt,
`endif
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             Stalling
);

  hz_state_t state_q, state_d;
  logic lu, jrex, jrmem, is_jr, is_jump;

  // ALU results in EX are forwarded, so RegWrite_ex never forces a stall.
  logic unused_regwrite;
  assign unused_regwrite = RegWrite_ex;

  assign is_jr   = (PCSrc == PCSRC_JR);
  assign is_jump = (PCSrc == PCSRC_J) || is_jr;

  assign lu    = MemRead_ex && (Write_register != '0) &&
                 ((UseRs && (Rs == Write_register)) || (UseRt && (Rt == Write_register)));
  assign jrex  = is_jr && MemRead_ex && (Write_register != '0) && (Rs == Write_register);
  assign jrmem = is_jr && MemRead_mem && (Write_register_mem != '0) && (Rs == Write_register_mem);

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = RUN;
    if (!BranchTaken_ex) begin
      case (state_q)
        RUN, STALL1: begin
          if (jrex)
            state_d = JR_WAIT1;
          else if (lu || jrmem)
            state_d = STALL1;
        end
        JR_WAIT1, JR_WAIT2: state_d = STALL1;
        default:            state_d = RUN;
      endcase
    end
  end

  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    if (!reset) begin
      if (BranchTaken_ex) begin
        IFIDFlush = 1'b1;
        IDEXFlush = 1'b1;
      end else begin
        case (state_q)
          RUN, STALL1: begin
            if (jrex || lu || jrmem) begin
              PCWrite   = 1'b0;
              IFIDWrite = 1'b0;
              IDEXFlush = 1'b1;
            end else if (is_jump) begin
              IFIDFlush = 1'b1;
            end
          end
          JR_WAIT1, JR_WAIT2: begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign Stalling = !PCWrite;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W_P-1:0] stall_cnt_q, flush_cnt_q;

  hazard_perf_counter #(.W(CNT_W_P)) u_stall_cnt (
    .clk   (clk),
    .clr   (reset),
    .en    (Stalling),
    .count (stall_cnt_q)
  );

  hazard_perf_counter #(.W(CNT_W_P)) u_flush_cnt (
    .clk   (clk),
    .clr   (reset),
    .en    (IFIDFlush),
    .count (flush_cnt_q)
  );

  // Masked so the counters read zero from the very first reset cycle.
  assign StallCnt = reset ? '0 : stall_cnt_q;
  assign FlushCnt = reset ? '0 : flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: driver queues expected outputs, monitor checks them.
module tb_hazard_stall_controller;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] PCSrc;
  logic [4:0] Rs, Rt, Write_register, Write_register_mem;
  logic       UseRs, UseRt, MemRead_ex, RegWrite_ex, MemRead_mem, BranchTaken_ex;
  logic       PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, Stalling;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] StallCnt, FlushCnt;
`endif

  always #5 clk = ~clk;

  hazard_stall_controller dut (
    .clk                (clk),
    .reset              (reset),
    .PCSrc              (PCSrc),
    .Rs                 (Rs),
    .Rt                 (Rt),
    .UseRs              (UseRs),
    .UseRt              (UseRt),
    .MemRead_ex         (MemRead_ex),
    .RegWrite_ex        (RegWrite_ex),
    .Write_register     (Write_register),
    .MemRead_mem        (MemRead_mem),
    .Write_register_mem (Write_register_mem),
    .BranchTaken_ex     (BranchTaken_ex),
`ifdef HAZARD_PERF_CNT_EN
    .StallCnt           (StallCnt),
    .FlushCnt           (FlushCnt),
`endif
    .PCWrite            (PCWrite),
    .IFIDWrite          (IFIDWrite),
    .IFIDFlush          (IFIDFlush),
    .IDEXFlush          (IDEXFlush),
    .Stalling           (Stalling)
  );

  // Expected vector bits: {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, Stalling}
  localparam logic [4:0] E_RUN   = 5'b11000;
  localparam logic [4:0] E_STALL = 5'b00011;
  localparam logic [4:0] E_JFL   = 5'b11100;
  localparam logic [4:0] E_BR    = 5'b11110;

  typedef struct {
    logic [4:0] exp;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // One cycle of stimulus: inputs held from posedge+1 until the next posedge+1.
  task automatic step(input logic rst, input logic [2:0] pcs,
                      input logic [4:0] rs_i, input logic [4:0] rt_i,
                      input logic urs, input logic urt,
                      input logic mre, input logic rwe, input logic [4:0] wr,
                      input logic mrm, input logic [4:0] wrm, input logic bt,
                      input logic [4:0] e, input string nm);
    exp_t t;
    @(posedge clk);
    #1;
    reset = rst; PCSrc = pcs; Rs = rs_i; Rt = rt_i; UseRs = urs; UseRt = urt;
    MemRead_ex = mre; RegWrite_ex = rwe; Write_register = wr;
    MemRead_mem = mrm; Write_register_mem = wrm; BranchTaken_ex = bt;
    t.exp = e; t.name = nm;
    exp_q.push_back(t);
  endtask

  task automatic idle(input logic [4:0] e, input string nm);
    step(1'b0, 3'b000, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, e, nm);
  endtask

  // Monitor: every cycle presents a decision, compared mid-cycle.
  initial begin
    exp_t t;
    logic [4:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        t   = exp_q.pop_front();
        act = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, Stalling};
        n_checks++;
        if (act === t.exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (PCWrite,IFIDWrite,IFIDFlush,IDEXFlush,Stalling)",
                      t.name, act, t.exp);
      end
    end
  end

  initial begin
    int unsigned guard;
    reset = 1'b1; PCSrc = '0; Rs = '0; Rt = '0; UseRs = 1'b0; UseRt = 1'b0;
    MemRead_ex = 1'b0; RegWrite_ex = 1'b0; Write_register = '0;
    MemRead_mem = 1'b0; Write_register_mem = '0; BranchTaken_ex = 1'b0;

    // Reset overrides a live load-use hazard
    step(1, 3'b000, 5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 0, 5'd0, 0, E_RUN, "reset_outputs");
    step(1, 3'b000, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, E_RUN, "reset_hold");

    // 1: lw $5 in EX, add uses $5 -> one stall, then release
    step(0, 3'b000, 5'd5, 5'd1, 1, 1, 1, 1, 5'd5, 0, 5'd0, 0, E_STALL, "lu_rs_stall");
    step(0, 3'b000, 5'd5, 5'd1, 1, 1, 0, 0, 5'd0, 1, 5'd5, 0, E_RUN,   "lu_release");

    // 2: lw $8 in EX, jr $8 -> two stalls, then jr redirect flush
    step(0, PCSRC_JR, 5'd8, 5'd0, 1, 0, 1, 1, 5'd8, 0, 5'd0, 0, E_STALL, "jrex_stall1");
    step(0, PCSRC_JR, 5'd8, 5'd0, 1, 0, 0, 0, 5'd0, 1, 5'd8, 0, E_STALL, "jrex_stall2");
    step(0, PCSRC_JR, 5'd8, 5'd0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, E_JFL,   "jrex_release_flush");
`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk);
    n_checks++;
    if (StallCnt === 32'd3) n_pass++;
    else $display("FAIL stall_cnt: got %0d expected 3", StallCnt);
`endif

    // 3: add $8 in EX, jr $8 -> forwarded, flush only
    step(0, PCSRC_JR, 5'd8, 5'd0, 1, 0, 0, 1, 5'd8, 0, 5'd0, 0, E_JFL, "jr_after_alu");
    // 4: lw $0 never creates a hazard
    step(0, 3'b000, 5'd0, 5'd0, 1, 1, 1, 1, 5'd0, 0, 5'd0, 0, E_RUN, "lw_r0_no_stall");
    // Rt hazard, and unused Rs match ignored
    step(0, 3'b000, 5'd3, 5'd7, 0, 1, 1, 1, 5'd7, 0, 5'd0, 0, E_STALL, "lu_rt_stall");
    step(0, 3'b000, 5'd7, 5'd2, 0, 1, 1, 1, 5'd7, 0, 5'd0, 0, E_RUN,   "unused_rs_match");
    // Back-to-back hazard re-evaluated from STALL1
    step(0, 3'b000, 5'd4, 5'd0, 1, 0, 1, 1, 5'd4, 0, 5'd0, 0, E_STALL, "b2b_first");
    step(0, 3'b000, 5'd6, 5'd0, 1, 0, 1, 1, 5'd6, 0, 5'd0, 0, E_STALL, "b2b_second");
    idle(E_RUN, "b2b_release");
    // jr with the load already in MEM -> single stall
    step(0, PCSRC_JR, 5'd9, 5'd0, 1, 0, 0, 0, 5'd0, 1, 5'd9, 0, E_STALL, "jrmem_stall");
    step(0, PCSRC_JR, 5'd9, 5'd0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, E_JFL,   "jrmem_release");
    // Plain j, and taken branch beating a load-use
    step(0, PCSRC_J, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, E_JFL, "j_flush");
    step(0, 3'b000, 5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 0, 5'd0, 1, E_BR,  "branch_over_lu");

    // 5: branch taken while in JR_WAIT1 aborts the stall
    step(0, PCSRC_JR, 5'd8, 5'd0, 1, 0, 1, 1, 5'd8, 0, 5'd0, 0, E_STALL, "jr_wait_enter");
    step(0, PCSRC_JR, 5'd8, 5'd0, 1, 0, 0, 0, 5'd0, 1, 5'd8, 1, E_BR,    "branch_in_jr_wait");
    idle(E_RUN, "after_branch_run");

    // 6: reset during STALL1, and during JR_WAIT1
    step(0, 3'b000, 5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 0, 5'd0, 0, E_STALL, "pre_reset_stall1");
    step(1, 3'b000, 5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 0, 5'd0, 0, E_RUN,   "reset_in_stall1");
    idle(E_RUN, "post_reset_stall1");
    step(0, PCSRC_JR, 5'd8, 5'd0, 1, 0, 1, 1, 5'd8, 0, 5'd0, 0, E_STALL, "pre_reset_jrwait");
    step(1, 3'b000, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, E_RUN,   "reset_in_jrwait");
    idle(E_RUN, "post_reset_jrwait");
`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk);
    n_checks++;
    if (StallCnt === 32'd0) n_pass++;
    else $display("FAIL stall_cnt_reset: got %0d expected 0", StallCnt);
`endif

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
